// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch and load/store), the arbiter and
// the single tiny8 memory port. The arbiter uses the slave view; the requester
// and memory side (core datapath or a test environment) uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  // instruction fetch requester
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  // load/store requester
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  // shared memory port
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  // watchdog abort pulse
  logic                  timeout_err;

  // arbiter view
  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp,
    output timeout_err
  );

  // requester + memory view
  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp,
    input  timeout_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the tiny8 memory port between instruction fetch (I) and
// load/store (D). Round-robin between the two, one transaction at a time, with
// a registered memory command and a watchdog that aborts a transaction whose
// memory response never arrives.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  // Counter is wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  // The counter holds the number of grant cycles already spent without a
  // response, so the abort fires on the TIMEOUT_CYCLES-th grant cycle.
  localparam logic [CNT_W-1:0] CNT_FIRE =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

  // Saturating increment: the counter never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  state_t                state_r, state_s;
  logic                  last_d_r, last_d_s;     // 1: last grant went to D
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  mem_read_r, mem_read_s;
  logic                  mem_write_r, mem_write_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;

  logic                  i_pend_s;
  logic                  d_pend_s;
  logic                  pick_i_s;
  logic                  granted_s;
  logic                  done_s;
  logic                  abort_s;

  // Decode pending requests and pick the round-robin winner for ST_IDLE.
  always_comb begin
    i_pend_s = bus.i_read;
    d_pend_s = bus.d_read | bus.d_write;
    pick_i_s = 1'b0;
    if (i_pend_s && d_pend_s) begin
      pick_i_s = last_d_r;
    end else begin
      pick_i_s = i_pend_s;
    end
  end

  // Classify the current grant cycle: normal completion, watchdog abort, or waiting.
  always_comb begin
    granted_s = (state_r == ST_GRANT_I) || (state_r == ST_GRANT_D);
    done_s    = 1'b0;
    abort_s   = 1'b0;
    if (granted_s) begin
      done_s  = bus.mem_resp;
      abort_s = WD_EN && !bus.mem_resp && (cnt_r >= CNT_FIRE);
    end else begin
      done_s  = 1'b0;
      abort_s = 1'b0;
    end
  end

  // Next-state and next memory command.
  always_comb begin
    state_s     = state_r;
    last_d_s    = last_d_r;
    cnt_s       = cnt_r;
    mem_read_s  = mem_read_r;
    mem_write_s = mem_write_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (pick_i_s) begin
          state_s     = ST_GRANT_I;
          last_d_s    = 1'b0;
          mem_addr_s  = bus.i_addr;
          mem_read_s  = 1'b1;
          mem_write_s = 1'b0;
        end else if (d_pend_s) begin
          state_s     = ST_GRANT_D;
          last_d_s    = 1'b1;
          mem_addr_s  = bus.d_addr;
          mem_wdata_s = bus.d_wdata;
          // a write wins when both read and write are requested
          mem_write_s = bus.d_write;
          mem_read_s  = !bus.d_write;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (done_s || abort_s) begin
          state_s     = ST_IDLE;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          cnt_s       = {CNT_W{1'b0}};
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        cnt_s       = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and memory command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      last_d_r    <= 1'b1;
      cnt_r       <= {CNT_W{1'b0}};
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      last_d_r    <= last_d_s;
      cnt_r       <= cnt_s;
      mem_read_r  <= mem_read_s;
      mem_write_r <= mem_write_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  // Route completion and read data to the granted requester only; zero elsewhere.
  always_comb begin
    bus.i_resp  = 1'b0;
    bus.i_rdata = {DATA_WIDTH{1'b0}};
    bus.d_resp  = 1'b0;
    bus.d_rdata = {DATA_WIDTH{1'b0}};
    if (state_r == ST_GRANT_I) begin
      bus.i_resp = done_s | abort_s;
      if (done_s) begin
        bus.i_rdata = bus.mem_rdata;
      end else begin
        bus.i_rdata = {DATA_WIDTH{1'b0}};
      end
    end else if (state_r == ST_GRANT_D) begin
      bus.d_resp = done_s | abort_s;
      if (done_s) begin
        bus.d_rdata = bus.mem_rdata;
      end else begin
        bus.d_rdata = {DATA_WIDTH{1'b0}};
      end
    end else begin
      bus.i_resp = 1'b0;
      bus.d_resp = 1'b0;
    end
  end

  assign bus.timeout_err = abort_s;
  assign bus.mem_read    = mem_read_r;
  assign bus.mem_write   = mem_write_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a table of directed per-cycle vectors covering the
// fetch, store, contention, input-stability, watchdog and reset scenarios,
// followed by randomized traffic compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       ir;
    logic [7:0] ia;
    logic       dr;
    logic       dw;
    logic [7:0] da;
    logic [7:0] dwd;
    logic       mresp;
    logic [7:0] mrd;
    logic       e_mr;
    logic       e_mw;
    logic [7:0] e_ma;
    logic [7:0] e_mwd;
    logic       e_ir;
    logic [7:0] e_ird;
    logic       e_dr;
    logic [7:0] e_drd;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rs, ir, input logic [7:0] ia, input logic dr, dw,
    input logic [7:0] da, dwd, input logic mresp, input logic [7:0] mrd,
    input logic e_mr, e_mw, input logic [7:0] e_ma, e_mwd,
    input logic e_ir, input logic [7:0] e_ird,
    input logic e_dr, input logic [7:0] e_drd, input logic e_to);
    vec_t v;
    v.rst = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.mresp = mresp; v.mrd = mrd;
    v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma; v.e_mwd = e_mwd;
    v.e_ir = e_ir; v.e_ird = e_ird; v.e_dr = e_dr; v.e_drd = e_drd; v.e_to = e_to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rs, ir, input logic [7:0] ia, input logic dr, dw,
                       input logic [7:0] da, dwd, input logic mresp, input logic [7:0] mrd);
    rst           = rs;
    bus.i_read    = ir;
    bus.i_addr    = ia;
    bus.d_read    = dr;
    bus.d_write   = dw;
    bus.d_addr    = da;
    bus.d_wdata   = dwd;
    bus.mem_resp  = mresp;
    bus.mem_rdata = mrd;
  endtask

  task automatic chk_all(input string tag, input logic e_mr, e_mw, input logic [7:0] e_ma, e_mwd,
                         input logic e_ir, input logic [7:0] e_ird, input logic e_dr,
                         input logic [7:0] e_drd, input logic chk_drd, input logic e_to);
    check({tag, ".mem_read"},    32'(bus.mem_read),    32'(e_mr));
    check({tag, ".mem_write"},   32'(bus.mem_write),   32'(e_mw));
    check({tag, ".mem_addr"},    32'(bus.mem_addr),    32'(e_ma));
    check({tag, ".mem_wdata"},   32'(bus.mem_wdata),   32'(e_mwd));
    check({tag, ".i_resp"},      32'(bus.i_resp),      32'(e_ir));
    check({tag, ".i_rdata"},     32'(bus.i_rdata),     32'(e_ird));
    check({tag, ".d_resp"},      32'(bus.d_resp),      32'(e_dr));
    if (chk_drd) check({tag, ".d_rdata"}, 32'(bus.d_rdata), 32'(e_drd));
    check({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(e_to));
  endtask

  // Transaction-level reference: at most one open transaction, who it belongs
  // to, how many grant cycles it has waited, and what the memory port shows.
  bit         m_busy, m_side_d, m_last_d, m_rd, m_wr;
  logic [7:0] m_addr, m_wdata;
  int         m_age;

  task automatic model_reset();
    m_busy = 1'b0; m_side_d = 1'b0; m_last_d = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
    m_addr = 8'h00; m_wdata = 8'h00; m_age = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // directed vectors, one row per cycle:
    // rst ir ia dr dw da dwd mresp mrd | mr mw ma mwd i_resp i_rdata d_resp d_rdata to
    // single fetch, response on the 4th grant cycle (watchdog boundary, no error)
    vecs.push_back(mk(0,1,8'h10,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h00,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h10,0,0,8'h00,8'h00,0,8'h00, 1,0,8'h10,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h10,0,0,8'h00,8'h00,0,8'h00, 1,0,8'h10,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h10,0,0,8'h00,8'h00,0,8'h00, 1,0,8'h10,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h10,0,0,8'h00,8'h00,1,8'hA5, 1,0,8'h10,8'h00, 1,8'hA5,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h10,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h10,8'h00, 0,8'h00,0,8'h00,0));
    // store with read+write both set: write wins
    vecs.push_back(mk(0,0,8'h00,1,1,8'h80,8'h3C,0,8'h00, 0,0,8'h10,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'h80,8'h3C,0,8'h00, 0,1,8'h80,8'h3C, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'h80,8'h3C,1,8'h00, 0,1,8'h80,8'h3C, 0,8'h00,1,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h80,8'h3C, 0,8'h00,0,8'h00,0));
    // persistent contention: I, D, I with one idle cycle between grants
    vecs.push_back(mk(0,1,8'h11,1,0,8'h22,8'h44,0,8'h00, 0,0,8'h80,8'h3C, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h11,1,0,8'h22,8'h44,1,8'h5A, 1,0,8'h11,8'h3C, 1,8'h5A,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h11,1,0,8'h22,8'h44,0,8'h00, 0,0,8'h11,8'h3C, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h11,1,0,8'h22,8'h44,1,8'hC3, 1,0,8'h22,8'h44, 0,8'h00,1,8'hC3,0));
    vecs.push_back(mk(0,1,8'h11,1,0,8'h22,8'h44,0,8'h00, 0,0,8'h22,8'h44, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h11,1,0,8'h22,8'h44,1,8'h01, 1,0,8'h11,8'h44, 1,8'h01,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h11,8'h44, 0,8'h00,0,8'h00,0));
    // input stability: address changes mid-grant are ignored
    vecs.push_back(mk(0,1,8'h10,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h11,8'h44, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h20,0,0,8'h00,8'h00,0,8'h00, 1,0,8'h10,8'h44, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h20,0,0,8'h00,8'h00,0,8'h00, 1,0,8'h10,8'h44, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h20,0,0,8'h00,8'h00,1,8'h99, 1,0,8'h10,8'h44, 1,8'h99,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h10,8'h44, 0,8'h00,0,8'h00,0));
    // watchdog: no response, abort on the 4th grant cycle with zero data
    vecs.push_back(mk(0,0,8'h00,1,0,8'h30,8'h00,0,8'h00, 0,0,8'h10,8'h44, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,1,0,8'h30,8'h00,0,8'h00, 1,0,8'h30,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,1,0,8'h30,8'h00,0,8'h00, 1,0,8'h30,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,1,0,8'h30,8'h00,0,8'h00, 1,0,8'h30,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,1,0,8'h30,8'h00,0,8'hFF, 1,0,8'h30,8'h00, 0,8'h00,1,8'h00,1));
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h30,8'h00, 0,8'h00,0,8'h00,0));
    // memory response while idle is ignored
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,1,8'hAB, 0,0,8'h30,8'h00, 0,8'h00,0,8'h00,0));
    // reset during a D grant, then contention goes to I first
    vecs.push_back(mk(0,0,8'h00,1,0,8'h40,8'h55,0,8'h00, 0,0,8'h30,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(1,0,8'h00,1,0,8'h40,8'h55,0,8'h00, 1,0,8'h40,8'h55, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h12,1,0,8'h41,8'h66,1,8'hEE, 0,0,8'h00,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,1,8'h12,1,0,8'h41,8'h66,0,8'h00, 1,0,8'h12,8'h00, 0,8'h00,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,1,8'h0F, 1,0,8'h12,8'h00, 1,8'h0F,0,8'h00,0));
    vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00,0,8'h00, 0,0,8'h12,8'h00, 0,8'h00,0,8'h00,0));

    // two cycles of reset, then sample the reset state
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    #1;
    chk_all("reset", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw,
            vecs[k].da, vecs[k].dwd, vecs[k].mresp, vecs[k].mrd);
      #1;
      chk_all($sformatf("vec%0d", k), vecs[k].e_mr, vecs[k].e_mw, vecs[k].e_ma, vecs[k].e_mwd,
              vecs[k].e_ir, vecs[k].e_ird, vecs[k].e_dr, vecs[k].e_drd, 1'b1, vecs[k].e_to);
      @(posedge clk);
      #1;
    end

    // randomized traffic against the transaction-level model
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      logic       r_rst, r_ir, r_dr, r_dw, r_mresp;
      logic [7:0] r_ia, r_da, r_dwd, r_mrd;
      bit         done, abort, grant_d;
      logic [7:0] e_ird, e_drd;
      r_rst   = ($urandom_range(99) < 2);
      r_ir    = ($urandom_range(99) < 50);
      r_dr    = ($urandom_range(99) < 40);
      r_dw    = ($urandom_range(99) < 30);
      r_mresp = ($urandom_range(99) < 35);
      r_ia    = 8'($urandom);
      r_da    = 8'($urandom);
      r_dwd   = 8'($urandom);
      r_mrd   = 8'($urandom);
      drive(r_rst, r_ir, r_ia, r_dr, r_dw, r_da, r_dwd, r_mresp, r_mrd);
      #1;
      done  = m_busy && r_mresp;
      abort = m_busy && !r_mresp && (TO > 0) && (m_age + 1 >= TO);
      e_ird = (done && !m_side_d) ? r_mrd : 8'h00;
      e_drd = (done && m_side_d) ? r_mrd : 8'h00;
      chk_all($sformatf("rnd%0d", n), m_rd, m_wr, m_addr, m_wdata,
              m_busy && !m_side_d && (done || abort), e_ird,
              m_busy && m_side_d && (done || abort), e_drd,
              !(done && m_side_d && m_wr), abort);
      // advance the model across the coming clock edge
      if (r_rst) begin
        model_reset();
      end else if (m_busy) begin
        if (done || abort) begin
          m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
        end else begin
          m_age++;
        end
      end else if (r_ir || r_dr || r_dw) begin
        grant_d  = (r_dr || r_dw) && (!r_ir || !m_last_d);
        m_busy   = 1'b1;
        m_age    = 0;
        m_side_d = grant_d;
        m_last_d = grant_d;
        if (grant_d) begin
          m_addr = r_da; m_wdata = r_dwd; m_wr = r_dw; m_rd = !r_dw;
        end else begin
          m_addr = r_ia; m_rd = 1'b1; m_wr = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single tiny8 memory port between two requesters: instruction fetch (I port) and load/store data access (D port).
- Sits between the control FSM/datapath and memory. Arbitrates with round-robin, latches the winning request, and drives a registered read/write to memory.
- Routes mem_resp and read data back to the granted requester only.
- Includes a watchdog counter so a missing memory response cannot hang the core.

Parameters:
ADDR_WIDTH  8  width of all address buses
DATA_WIDTH  8  width of all data buses
TIMEOUT_CYCLES  255  cycles in a grant state without mem_resp before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
i_read  in  1  fetch read request, level, held until i_resp
i_addr  in  ADDR_WIDTH  fetch address
i_rdata  out  DATA_WIDTH  fetch read data, valid when i_resp=1
i_resp  out  1  one-cycle fetch completion pulse
d_read  in  1  data read request, level
d_write  in  1  data write request, level
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_rdata  out  DATA_WIDTH  load data, valid when d_resp=1
d_resp  out  1  one-cycle data completion pulse
mem_read  out  1  registered memory read strobe
mem_write  out  1  registered memory write strobe
mem_addr  out  ADDR_WIDTH  registered memory address
mem_wdata  out  DATA_WIDTH  registered memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_resp
mem_resp  in  1  memory completion pulse
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- **States:** ST_IDLE, ST_GRANT_I, ST_GRANT_D.
- **Reset (rst=1 at a clock edge):**
  - state=ST_IDLE; mem_read, mem_write, timeout_err = 0.
  - mem_addr and mem_wdata = 0; watchdog counter = 0.
  - last_grant = D, so the first contention goes to I.
  - Reset mid-transaction abandons it; no resp is issued to either requester.
- **ST_IDLE:**
  - I pending = i_read. D pending = d_read|d_write.
  - Only one pending: grant it.
  - Both pending: grant the side not equal to last_grant.
  - Grant to I: next state ST_GRANT_I; latch mem_addr=i_addr, mem_read=1.
  - Grant to D: next state ST_GRANT_D; latch mem_addr=d_addr and mem_wdata=d_wdata.
    - d_write=1 gives mem_write=1, mem_read=0. Write wins if d_read and d_write are both set.
    - Otherwise mem_read=1.
  - Update last_grant.
  - Latency: request seen in IDLE at edge N gives a memory strobe visible after edge N+1 (one cycle).
- **ST_GRANT_x:**
  - mem_* hold their latched values. Requester inputs are ignored (changes do not affect the bus).
  - Counter increments every cycle while mem_resp=0.
- **Completion (mem_resp=1 in ST_GRANT_x):**
  - x_resp=1 combinationally in the same cycle.
  - x_rdata = mem_rdata combinationally (d_rdata is don't-care for writes).
  - Next edge: state=ST_IDLE, mem_read=mem_write=0, counter=0.
- **Non-granted requester:**
  - Its resp stays 0 and its rdata = 0.
  - x_rdata = 0 whenever x_resp=0.
- **Requester deassertion:** the requester must drop its request in the cycle after x_resp. A request still high in ST_IDLE is treated as a new request.
- **Back-to-back fairness:** ST_IDLE is always visited for at least one cycle between transactions. Persistent requests from both sides therefore alternate I, D, I, D.
- **Watchdog** (TIMEOUT_CYCLES>0):
  - Fires when the counter reaches TIMEOUT_CYCLES in a grant state and mem_resp=0 that cycle.
  - On firing: timeout_err=1 and x_resp=1 with x_rdata=0, both for one cycle.
  - Next edge: state=ST_IDLE, strobes cleared, counter=0.
  - mem_resp in the same cycle the watchdog would fire counts as normal completion; no error.
- **mem_resp in ST_IDLE:** ignored; no resp is forwarded.
- **Counter width:** sized to hold TIMEOUT_CYCLES; saturates and never wraps.

Test Plan:
- **Reset then single fetch:** rst 2 cycles, then i_read=1, i_addr=0x10.
  - Next cycle: mem_read=1, mem_addr=0x10, mem_write=0.
  - Memory returns mem_resp=1, mem_rdata=0xA5 three cycles later: same cycle i_resp=1, i_rdata=0xA5, d_resp=0.
  - Following cycle: mem_read=0.
- **Store:** d_write=1, d_read=1, d_addr=0x80, d_wdata=0x3C.
  - mem_write=1, mem_read=0, mem_addr=0x80, mem_wdata=0x3C.
  - On mem_resp: d_resp=1 for one cycle.
- **Contention after reset:** i_read=1 and d_read=1 held continuously.
  - Grant order I, D, I, D, checked via mem_addr.
  - Exactly one cycle of ST_IDLE (strobes low) between grants.
- **Input stability:** change i_addr from 0x10 to 0x20 mid-grant.
  - mem_addr stays 0x10 until completion.
- **Watchdog:** TIMEOUT_CYCLES=4, d_read=1, mem_resp never asserted.
  - After 4 grant cycles: timeout_err=1, d_resp=1, d_rdata=0.
  - Next cycle: strobes low.
  - A mem_resp arriving on the 4th cycle instead gives no timeout_err.
- **Reset mid-operation:** assert rst during ST_GRANT_D.
  - Next edge: all mem strobes 0, no d_resp.
  - Subsequent contention grants I first.
